rr_arbiter4: RTL

Four-requester round-robin arbiter that shares a single one-hot select resource, the 2-to-4 decoder, among four masters. It picks one requester at a time, holds the grant while that requester keeps its request asserted, and forces rotation once a hold limit is reached and another requester is waiting. The winner index drives an internal 2x4 decoder to produce the one-hot grant bus that the downstream datapath uses as its select.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/decoder_2x4.sv | 22 ++
 rtl/rr_arbiter4.sv | 106 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and round-robin search for rr_arbiter4
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  // Rotate so bit 0 is the ptr requester, take the lowest set bit, rotate back.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    dbl = {r, r};
    rot = dbl[p +: NREQ];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    return off + p;
  endfunction

endpackage

// File: rtl/decoder_2x4.sv
// rtl/decoder_2x4.sv - gate-level 2-to-4 one-hot decoder
module decoder_2x4 (
  input  logic s1,
  input  logic s0,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3
);

  logic s1_n;
  logic s0_n;

  not u_inv1 (s1_n, s1);
  not u_inv0 (s0_n, s0);

  and u_and0 (o0, s1_n, s0_n);
  and u_and1 (o1, s1_n, s0);
  and u_and2 (o2, s1,   s0_n);
  and u_and3 (o3, s1,   s0);

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold limit and one-hot grant
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic            pre_q, pre_d;

  logic [NREQ-1:0] own_bit;
  logic [NREQ-1:0] others;
  logic [IDW-1:0]  win_all;
  logic [IDW-1:0]  win_oth;
  logic [NREQ-1:0] dec;

  always_comb begin
    own_bit        = '0;
    own_bit[id_q]  = 1'b1;
    others         = req & ~own_bit;
    win_all        = rr_pick(req, ptr_q);
    win_oth        = rr_pick(others, ptr_q);

    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          id_d    = win_all;
          ptr_d   = win_all + IDW'(1);
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!req[id_q]) begin
          // Owner released: hand straight to the next waiter, no idle gap.
          if (|others) begin
            id_d   = win_all;
            ptr_d  = win_all + IDW'(1);
            hold_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((hold_q == HOLD_LAST) && (|others)) begin
          id_d   = win_oth;
          ptr_d  = win_oth + IDW'(1);
          hold_d = '0;
          pre_d  = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  decoder_2x4 u_dec (
    .s1 (id_q[1]),
    .s0 (id_q[0]),
    .o0 (dec[0]),
    .o1 (dec[1]),
    .o2 (dec[2]),
    .o3 (dec[3])
  );

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt       = dec & {NREQ{gnt_valid}};
  assign gnt_id    = id_q;
  assign preempt   = pre_q;

endmodule
